mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised data and instruction memory for the CPU. It contains a dual-port synchronous word RAM with configurable depth. Port A serves load and store requests over a valid/ready handshake and implements BYTE, HALFWORD, WORD, WORDLEFT and WORDRIGHT modes, using the `MemoryModesPackage::ReadWriteModes` encodings. Loads perform correct per-lane sign extension and LWL/LWR register merge, and an access that spans two words is split into two RAM accesses. Port B is a read-only instruction fetch port with one-cycle latency.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address bits used. Word index is `addr[ADDR_W-1:2]`; upper address bits are ignored.
- `DEPTH_WORDS`, `2**(ADDR_W-2)`: number of RAM words. Must equal `2**(ADDR_W-2)`.

Ports:
- `clk` in 1: the single clock. All logic is rising-edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: a data request is present.
- `req_ready` out 1: the block accepts a request. A transfer occurs when `req_valid && req_ready`.
- `req_write` in 1: 1 selects a store, 0 selects a load.
- `req_mode` in 3: `ReadWriteModes`. `ReadWriteMode_NONE` with `req_valid` is acknowledged and does nothing.
- `req_unsigned` in 1: zero-extends BYTE and HALFWORD loads.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data. For WORDLEFT/WORDRIGHT loads it is the old register value used for the merge.
- `rsp_valid` out 1: a one-cycle pulse per accepted request.
- `rsp_rdata` out 32: load result. It is 0 for stores and for errors.
- `rsp_err` out 1: valid only with `rsp_valid`. It flags a rejected spanning access.
- `pc_addr` in 32: instruction byte address.
- `pc_rdata` out 32: instruction word, one cycle after `pc_addr`.

## Operation
- Memory is little-endian: byte offset `o = addr[1:0]`, and byte 0 is bits `[7:0]`.
- Stores:
  - BYTE writes lane `o`.
  - HALFWORD writes lanes `o..o+1`.
  - WORD writes lanes `0..3`.
  - WORDLEFT (SWL) writes the top `o+1` bytes of `req_wdata` into lanes `0..o`.
  - WORDRIGHT (SWR) writes the low `4-o` bytes into lanes `o..3`.
- Loads:
  - BYTE and HALFWORD take the lanes listed for stores. The sign bit is the MSB of the selected lane or lanes, not bit 7 or bit 15 of the raw word.
  - WORDLEFT (LWL): the result's top `o+1` bytes are lanes `0..o`; the remaining low bytes come from `req_wdata`.
  - WORDRIGHT (LWR): the result's low `4-o` bytes are lanes `o..3`; the remaining high bytes come from `req_wdata`.
- A spanning access is HALFWORD with `o==3`, or WORD with `o!=0`. It touches word `k` (lanes `o..3`) and word `k+1` (the remaining lanes). The word index `k+1` wraps modulo `DEPTH_WORDS`.
- WORDLEFT and WORDRIGHT never span.
- FSM states:
  - IDLE: `req_ready`=1. A non-spanning request completes here. A spanning request (macro enabled) performs its first access in the accept cycle, then moves to SPLIT.
  - SPLIT: `req_ready`=0. Performs the word `k+1` access using address, mode and data registered at accept, then returns to IDLE.
- A split load assembles the result from both words before extension.
- Port B is always reading. If it reads the word port A writes in the same cycle, it returns the old data (read-before-write).
- RAM contents are not reset.

## Timing
- Reset values: `req_ready`=1 (state IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `pc_rdata`=0. Internal request registers are cleared.
- Non-spanning request accepted in cycle N:
  - RAM access occurs in cycle N.
  - `rsp_valid` is high in N+1.
  - Back-to-back accepts every cycle are sustained.
- Spanning request accepted in cycle N (macro enabled):
  - Access 1 in N, access 2 in N+1.
  - `req_ready`=0 in N+1.
  - `rsp_valid` in N+2.
  - `req_ready`=1 again in N+2.
- `rsp_valid` has no backpressure; the consumer must take it.
- `pc_rdata` follows `pc_addr` with 1-cycle latency, unconditionally.
- Reset asserted in SPLIT:
  - The second access is abandoned; the first-half store lanes remain written.
  - No `rsp_valid` is issued.
- A request presented while `req_ready`=0 is ignored and must be held by the requester.

## Configuration
- `MEM_SPLIT_UNALIGNED_EN` defined:
  - Spanning accesses are split as described.
  - `rsp_err` is tied to 0.
- `MEM_SPLIT_UNALIGNED_EN` undefined:
  - A spanning access is answered in N+1 with `rsp_err`=1 and `rsp_rdata`=0.
  - No lanes are written.
  - The SPLIT state does not exist, so `req_ready` is constantly 1 after reset.

## Test plan
- BYTE store of `0x000000A5` to 0x101, then signed BYTE load of 0x101 -> `0xFFFFFFA5` at N+1. Unsigned load of the same address -> `0x000000A5`. Lanes 0, 2 and 3 of word 0x100 are unchanged.
- WORD store of `0x11223344` to 0x200; LWL at 0x201 with `req_wdata`=`0xAABBCCDD` -> `0x3344CCDD`; LWR at 0x202 with the same merge value -> `0xAABB1122`.
- Macro enabled: WORD `0xDEADBEEF` stored to 0x303 -> word 0x300 lane 3 = `0xEF` and word 0x304 lanes 0..2 = `0xDEADBE`. WORD load of 0x303 -> `0xDEADBEEF`, with `rsp_valid` at N+2 and `req_ready` low at N+1.
- Macro disabled: HALFWORD store to 0x403 -> `rsp_err`=1 and `rsp_rdata`=0 at N+1. Memory is unchanged when word 0x400 and word 0x404 are read back.
- Store to the word at `pc_addr` in the same cycle -> `pc_rdata` shows the old word; the next cycle shows the new word. Spanning WORD at the last address, offset 1, wraps its second word to word 0.
- `rst` pulsed while in SPLIT -> no response. `req_ready`=1 and `rsp_valid`=0 are seen immediately, asynchronously.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: data + instruction memory for the CPU.
//
// A dual-port synchronous word RAM. Port A is a load/store port behind a
// valid/ready handshake that supports BYTE, HALFWORD, WORD, WORDLEFT (LWL/SWL)
// and WORDRIGHT (LWR/SWR) accesses, with per-lane sign extension and register
// merge. Port B is a read-only instruction fetch port with one-cycle latency.
//
// Optional feature macro: MEM_SPLIT_UNALIGNED_EN
//   defined   - accesses that span two words are split over two cycles.
//   undefined - spanning accesses are rejected with rsp_err and write nothing.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    request handshake
//   req_write          1 = store, 0 = load
//   req_mode           MemoryModesPackage::ReadWriteModes encoding
//   req_unsigned       zero-extend BYTE/HALFWORD loads
//   req_addr           byte address (bits above ADDR_W ignored)
//   req_wdata          store data, or old register value for LWL/LWR merge
//   rsp_valid          one-cycle pulse per accepted request
//   rsp_rdata          load result (0 for stores and errors)
//   rsp_err            rejected spanning access
//   pc_addr, pc_rdata  instruction fetch address and word (1-cycle latency)

package MemoryModesPackage;
  typedef enum logic [2:0] {
    ReadWriteMode_NONE      = 3'd0,
    ReadWriteMode_BYTE      = 3'd1,
    ReadWriteMode_HALFWORD  = 3'd2,
    ReadWriteMode_WORD      = 3'd3,
    ReadWriteMode_WORDLEFT  = 3'd4,
    ReadWriteMode_WORDRIGHT = 3'd5
  } ReadWriteModes;
endpackage

module mem_access_unit
  import MemoryModesPackage::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 2 ** (ADDR_W - 2)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_mode,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [31:0] pc_addr,
  output logic [31:0] pc_rdata
);

`ifdef MEM_SPLIT_UNALIGNED_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  localparam int unsigned IdxW = ADDR_W - 2;

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  state_e state_q, state_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Request decode: byte enables and data laid out over two consecutive words.
  logic [1:0]      req_off;
  logic [IdxW-1:0] req_idx;
  logic [7:0]      req_be8;
  logic [63:0]     req_wd64;
  logic            req_span;
  logic            accept;

  assign req_off = req_addr[1:0];
  assign req_idx = req_addr[ADDR_W-1:2];
  assign accept  = req_valid && req_ready;

  always_comb begin
    req_be8  = 8'h00;
    req_wd64 = {32'h0, req_wdata} << {req_off, 3'b000};
    case (req_mode)
      ReadWriteMode_BYTE:      req_be8 = 8'h01 << req_off;
      ReadWriteMode_HALFWORD:  req_be8 = 8'h03 << req_off;
      ReadWriteMode_WORD:      req_be8 = 8'h0F << req_off;
      ReadWriteMode_WORDLEFT: begin
        // Top off+1 bytes of the register go to lanes 0..off.
        req_be8  = 8'h0F >> (2'd3 - req_off);
        req_wd64 = {32'h0, req_wdata >> {2'd3 - req_off, 3'b000}};
      end
      ReadWriteMode_WORDRIGHT: req_be8 = (8'h0F << req_off) & 8'h0F;
      default: ;
    endcase
    // Only HALFWORD/WORD can push enables into the next word.
    req_span = |req_be8[7:4];
  end

  // Request registers captured at accept.
  logic            write_q;
  logic [2:0]      mode_q;
  logic            unsigned_q;
  logic [1:0]      off_q;
  logic [31:0]     wdata_q;
  logic [IdxW-1:0] idx_q;
  logic [3:0]      hi_be_q;
  logic [31:0]     hi_data_q;
  logic            spanned_q;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rd_q;
  logic [31:0]     lo_q;

  // Port A RAM control.
  logic            wr_en;
  logic [IdxW-1:0] wr_idx;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;
  logic [IdxW-1:0] rd_idx;
  logic            lo_load;

  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    wr_idx      = req_idx;
    wr_be       = req_be8[3:0];
    wr_data     = req_wd64[31:0];
    rd_idx      = req_idx;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    lo_load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_span && !SplitEn) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            wr_en = req_write;
            if (req_span) begin
              state_d = StSplit;
            end else begin
              rsp_valid_d = 1'b1;
            end
          end
        end
      end
      StSplit: begin
        // Second word, wrapping naturally at the top of the RAM.
        wr_idx      = idx_q + 1'b1;
        rd_idx      = idx_q + 1'b1;
        wr_be       = hi_be_q;
        wr_data     = hi_data_q;
        wr_en       = write_q;
        lo_load     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A reset abandons whatever access was in flight.
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      write_q     <= 1'b0;
      mode_q      <= 3'd0;
      unsigned_q  <= 1'b0;
      off_q       <= 2'd0;
      wdata_q     <= 32'h0;
      idx_q       <= '0;
      hi_be_q     <= 4'h0;
      hi_data_q   <= 32'h0;
      spanned_q   <= 1'b0;
      rd_q        <= 32'h0;
      lo_q        <= 32'h0;
      pc_rdata    <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      // Reads sample the RAM before this edge's write lands (read-before-write).
      rd_q        <= mem[rd_idx];
      pc_rdata    <= mem[pc_addr[ADDR_W-1:2]];
      if (lo_load) lo_q <= rd_q;
      if (accept) begin
        write_q    <= req_write;
        mode_q     <= req_mode;
        unsigned_q <= req_unsigned;
        off_q      <= req_off;
        wdata_q    <= req_wdata;
        idx_q      <= req_idx;
        hi_be_q    <= req_be8[7:4];
        hi_data_q  <= req_wd64[63:32];
        spanned_q  <= req_span & SplitEn;
      end
    end
  end

  // Load result: view the two words as a little-endian byte stream starting
  // at the access offset, then extend or merge.
  logic [31:0] word_lo;
  logic [63:0] stream;
  logic [31:0] load_data;

  always_comb begin
    word_lo   = spanned_q ? lo_q : rd_q;
    stream    = {rd_q, word_lo} >> {off_q, 3'b000};
    load_data = 32'h0;
    case (mode_q)
      ReadWriteMode_BYTE:
        load_data = unsigned_q ? {24'h0, stream[7:0]} : {{24{stream[7]}}, stream[7:0]};
      ReadWriteMode_HALFWORD:
        load_data = unsigned_q ? {16'h0, stream[15:0]} : {{16{stream[15]}}, stream[15:0]};
      ReadWriteMode_WORD:
        load_data = stream[31:0];
      ReadWriteMode_WORDLEFT:
        load_data = (rd_q << {2'd3 - off_q, 3'b000}) |
                    (wdata_q & (32'h00FF_FFFF >> {off_q, 3'b000}));
      ReadWriteMode_WORDRIGHT:
        load_data = (rd_q >> {off_q, 3'b000}) |
                    (wdata_q & ~(32'hFFFF_FFFF >> {off_q, 3'b000}));
      default: load_data = 32'h0;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = SplitEn ? 1'b0 : rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !write_q && !rsp_err_q) ? load_data : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W], pc_addr[31:ADDR_W], pc_addr[1:0], stream[63:32]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed steps from the test plan
// followed by randomized traffic checked against a byte-array memory model.
module tb_mem_access_unit;

  localparam logic [2:0] M_NONE = 3'd0;
  localparam logic [2:0] M_BYTE = 3'd1;
  localparam logic [2:0] M_HALF = 3'd2;
  localparam logic [2:0] M_WORD = 3'd3;
  localparam logic [2:0] M_WL   = 3'd4;
  localparam logic [2:0] M_WR   = 3'd5;

`ifdef MEM_SPLIT_UNALIGNED_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_mode = 3'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] pc_addr = 32'h0;
  logic [31:0] pc_rdata;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_mode     (req_mode),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .pc_addr      (pc_addr),
    .pc_rdata     (pc_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [65536];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_span(input logic [2:0] m, input logic [31:0] a);
    return (m == M_HALF && a[1:0] == 2'd3) || (m == M_WORD && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int unsigned base;
    base = 32'(a[15:0]) & 32'hFFFC;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  // Byte-level model of one access; updates ref_mem for stores.
  function automatic void model_access(input logic w, input logic [2:0] m, input logic u,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] r, output logic e);
    int unsigned b, o, base, n;
    b = 32'(a[15:0]);
    o = b % 4;
    base = b - o;
    r = 32'h0;
    e = 1'b0;
    n = 0;
    if (is_span(m, a) && !SplitEn) begin
      e = 1'b1;
      return;
    end
    if (m == M_BYTE) n = 1;
    if (m == M_HALF) n = 2;
    if (m == M_WORD) n = 4;
    if (n != 0) begin
      for (int i = 0; i < n; i++) begin
        if (w) ref_mem[(b + i) % 65536] = d[8*i +: 8];
        else r[8*i +: 8] = ref_mem[(b + i) % 65536];
      end
      if (!u && n == 1) r = {{24{r[7]}}, r[7:0]};
      if (!u && n == 2) r = {{16{r[15]}}, r[15:0]};
    end else if (m == M_WL) begin
      r = d;
      for (int i = 0; i <= int'(o); i++) begin
        if (w) ref_mem[base + i] = d[8*(3 - o + i) +: 8];
        else r[8*(3 - o + i) +: 8] = ref_mem[base + i];
      end
    end else if (m == M_WR) begin
      r = d;
      for (int i = int'(o); i < 4; i++) begin
        if (w) ref_mem[base + i] = d[8*(i - o) +: 8];
        else r[8*(i - o) +: 8] = ref_mem[base + i];
      end
    end
    if (w) r = 32'h0;
  endfunction

  // One request with idle around it; checks latency, ready, data and error.
  task automatic txn(input string tag, input logic w, input logic [2:0] m, input logic u,
                     input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    logic [31:0] er;
    logic        ee;
    logic        rdy1;
    int          exp_lat, lat;
    exp_lat = (is_span(m, a) && SplitEn) ? 2 : 1;
    model_access(w, m, u, a, d, er, ee);
    check32({tag, "/ready_n"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_mode = m; req_unsigned = u;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdy1 = req_ready;
    lat = 1;
    while (!rsp_valid && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    got = rsp_rdata;
    check32({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check32({tag, "/ready_n1"}, 32'(rdy1), (exp_lat == 2) ? 32'd0 : 32'd1);
    check32({tag, "/rdata"}, rsp_rdata, er);
    check32({tag, "/err"}, 32'(rsp_err), 32'(ee));
  endtask

  // Back-to-back non-spanning requests, valid held high every cycle.
  task automatic burst(input string tag, input int n, input bit init, input int unsigned start_word);
    logic [31:0] exp_q[$];
    logic [31:0] er, a, d;
    logic        ee, w, u;
    logic [2:0]  m;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        if (init) begin
          w = 1'b1; m = M_WORD; u = 1'b0;
          a = 32'((start_word + 32'(i)) * 4);
        end else begin
          w = 1'($urandom_range(0, 1));
          m = 3'($urandom_range(0, 5));
          u = 1'($urandom_range(0, 1));
          a = 32'($urandom_range(0, 'h7FF));
          if (m == M_WORD) a[1:0] = 2'd0;
          if (m == M_HALF && a[1:0] == 2'd3) a[1:0] = 2'd2;
        end
        d = $urandom;
        model_access(w, m, u, a, d, er, ee);
        exp_q.push_back(er);
        req_valid = 1'b1; req_write = w; req_mode = m; req_unsigned = u;
        req_addr = a; req_wdata = d;
      end else begin
        req_valid = 1'b0;
      end
      if (i > 0) begin
        check32({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        check32({tag, "/ready"}, 32'(req_ready), 32'd1);
        check32({tag, "/rdata"}, rsp_rdata, exp_q.pop_front());
      end
      if (i < n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [31:0] got, d, old;
    logic [31:0] er;
    logic        ee;

    // Reset values while reset is held.
    #1;
    check32("rst_ready", 32'(req_ready), 32'd1);
    check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check32("rst_rsp_rdata", rsp_rdata, 32'd0);
    check32("rst_rsp_err", 32'(rsp_err), 32'd0);
    check32("rst_pc_rdata", pc_rdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Give every word the bench will read a known value.
    burst("init_lo", 512, 1'b1, 0);
    burst("init_hi", 2, 1'b1, 16382);

    // Byte store and signed/unsigned byte loads.
    txn("sb", 1'b1, M_BYTE, 1'b0, 32'h101, 32'h0000_00A5, got);
    txn("lb", 1'b0, M_BYTE, 1'b0, 32'h101, 32'h0, got);
    check32("lb_const", got, 32'hFFFF_FFA5);
    txn("lbu", 1'b0, M_BYTE, 1'b1, 32'h101, 32'h0, got);
    check32("lbu_const", got, 32'h0000_00A5);
    txn("lw_100", 1'b0, M_WORD, 1'b0, 32'h100, 32'h0, got);

    // LWL / LWR merge.
    txn("sw_200", 1'b1, M_WORD, 1'b0, 32'h200, 32'h1122_3344, got);
    txn("lwl", 1'b0, M_WL, 1'b0, 32'h201, 32'hAABB_CCDD, got);
    check32("lwl_const", got, 32'h3344_CCDD);
    txn("lwr", 1'b0, M_WR, 1'b0, 32'h202, 32'hAABB_CCDD, got);
    check32("lwr_const", got, 32'hAABB_1122);

    // Spanning word.
    txn("sw_303", 1'b1, M_WORD, 1'b0, 32'h303, 32'hDEAD_BEEF, got);
    txn("lw_303", 1'b0, M_WORD, 1'b0, 32'h303, 32'h0, got);
    check32("lw_303_const", got, SplitEn ? 32'hDEAD_BEEF : 32'h0);
    txn("lw_300", 1'b0, M_WORD, 1'b0, 32'h300, 32'h0, got);
    txn("lw_304", 1'b0, M_WORD, 1'b0, 32'h304, 32'h0, got);

    // Spanning halfword.
    txn("sh_403", 1'b1, M_HALF, 1'b0, 32'h403, 32'h0000_BEEF, got);
    txn("lw_400", 1'b0, M_WORD, 1'b0, 32'h400, 32'h0, got);
    txn("lw_404", 1'b0, M_WORD, 1'b0, 32'h404, 32'h0, got);
    txn("lh_403", 1'b0, M_HALF, 1'b0, 32'h403, 32'h0, got);

    // Fetch port read-before-write.
    pc_addr = 32'h100;
    old = ref_word(32'h100);
    d = 32'h0BAD_F00D;
    model_access(1'b1, M_WORD, 1'b0, 32'h100, d, er, ee);
    req_valid = 1'b1; req_write = 1'b1; req_mode = M_WORD; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check32("pc_rbw_old", pc_rdata, old);
    check32("pc_rbw_rsp", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    check32("pc_rbw_new", pc_rdata, d);
    pc_addr = 32'hFFFF_0204;
    @(posedge clk); #1;
    check32("pc_204", pc_rdata, ref_word(32'h204));

    // Wrap from the last word to word 0.
    txn("sw_wrap", 1'b1, M_WORD, 1'b0, 32'hFFFD, 32'hCAFE_F00D, got);
    txn("lw_wrap", 1'b0, M_WORD, 1'b0, 32'h1234_FFFD, 32'h0, got);
    check32("lw_wrap_const", got, SplitEn ? 32'hCAFE_F00D : 32'h0);
    txn("lw_fffc", 1'b0, M_WORD, 1'b0, 32'hFFFC, 32'h0, got);
    txn("lw_0", 1'b0, M_WORD, 1'b0, 32'h0, 32'h0, got);

    // Reset during the second half of a split store.
    d = 32'h5A6B_7C8D;
    check32("rsplit/ready_pre", 32'(req_ready), 32'd1);
    if (SplitEn) ref_mem['h503] = d[7:0];
    req_valid = 1'b1; req_write = 1'b1; req_mode = M_WORD; req_unsigned = 1'b0;
    req_addr = 32'h503; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check32("rsplit/ready_n1", 32'(req_ready), SplitEn ? 32'd0 : 32'd1);
    check32("rsplit/valid_n1", 32'(rsp_valid), SplitEn ? 32'd0 : 32'd1);
    #2 rst = 1'b1;
    #1;
    check32("rsplit/ready_async", 32'(req_ready), 32'd1);
    check32("rsplit/valid_async", 32'(rsp_valid), 32'd0);
    check32("rsplit/err_async", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check32("rsplit/valid_a", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check32("rsplit/valid_b", 32'(rsp_valid), 32'd0);
    txn("rsplit/lw_500", 1'b0, M_WORD, 1'b0, 32'h500, 32'h0, got);
    txn("rsplit/lw_504", 1'b0, M_WORD, 1'b0, 32'h504, 32'h0, got);

    // Randomized single requests, including spanning ones.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = {16'($urandom), 16'($urandom_range(0, 'h7F7))};
      txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)),
          1'($urandom_range(0, 1)), a, $urandom, got);
    end

    // Randomized back-to-back traffic.
    burst("b2b", 64, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
